// File: rtl/pressao_pkg.sv
// Shared constants, types and helpers for the pressure-sensor conditioner.
// Channel order follows the packing of the raw and filtered buses, SC in the low nibble.
package pressao_pkg;

  localparam int NUM_CANAIS = 7;
  localparam int LARGURA    = 4;
  localparam logic [LARGURA-1:0] COD_FALHA = 4'b1000;

  localparam int SC    = 0;
  localparam int S1    = 1;
  localparam int S2    = 2;
  localparam int S3    = 3;
  localparam int TUBSR = 4;
  localparam int TUBSS = 5;
  localparam int REA   = 6;

  typedef enum logic [1:0] {
    VAZIO,
    ENCHENDO,
    OPERANDO
  } estado_t;

  typedef logic signed [LARGURA-1:0] amostra_t;

  // Sign-extends a sample to the 6-bit width that holds the sum of four samples.
  function automatic logic signed [5:0] estende(input amostra_t a);
    return {{2{a[LARGURA-1]}}, a};
  endfunction

endpackage

// File: rtl/condicionador_pressao_if.sv
// Strobe, raw-sample and conditioned-output bundle between a sample source and the conditioner.
interface condicionador_pressao_if import pressao_pkg::*; ();

  logic                          amostraEn;
  logic                          limparFalha;
  logic [NUM_CANAIS*LARGURA-1:0] sensBruto;
  logic [NUM_CANAIS*LARGURA-1:0] sensPres;
  logic                          dadosValidos;
  logic [NUM_CANAIS-1:0]         falhaSensor;
  logic [NUM_CANAIS-1:0]         travado;
  logic                          alarmeSensor;

  modport master (
    output amostraEn, limparFalha, sensBruto,
    input  sensPres, dadosValidos, falhaSensor, travado, alarmeSensor
  );

  modport slave (
    input  amostraEn, limparFalha, sensBruto,
    output sensPres, dadosValidos, falhaSensor, travado, alarmeSensor
  );

endinterface

// File: rtl/canal_filtro.sv
// One pressure channel: 4-sample moving-average window, fault-code substitution
// with a sticky fault flag, and a stuck-value detector.
module canal_filtro import pressao_pkg::*; #(
  parameter int LIMITE_TRAVADO = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     i_amostra_en,
  input  logic     i_limpar_falha,
  input  amostra_t i_bruto,
  output amostra_t o_filtrado,
  output logic     o_falha,
  output logic     o_travado
);

  localparam int LARG_CONT = $clog2(LIMITE_TRAVADO + 1);
  localparam logic [LARG_CONT-1:0] LIMITE = LARG_CONT'(LIMITE_TRAVADO);

  amostra_t              r_janela [4];
  amostra_t              r_ultimo;
  logic [LARG_CONT-1:0]  r_cont;
  logic                  r_falha;
  logic                  r_travado;

  logic                  w_eh_falha;
  amostra_t              w_aceita;
  logic [LARG_CONT-1:0]  w_cont_prox;
  logic signed [5:0]     w_soma;

  // A fault code repeats the newest accepted sample, which is 0 straight after reset.
  assign w_eh_falha = (i_bruto == COD_FALHA);
  assign w_aceita   = w_eh_falha ? r_janela[0] : i_bruto;

  // NOTE: assign every always_comb output before any condition, otherwise a latch is inferred.
  always_comb begin
    w_cont_prox = LARG_CONT'(1);
    if (r_cont != '0 && i_bruto == r_ultimo)
      w_cont_prox = (r_cont == LIMITE) ? LIMITE : r_cont + 1'b1;
  end

  assign w_soma = estende(r_janela[0]) + estende(r_janela[1])
                + estende(r_janela[2]) + estende(r_janela[3]);
  assign o_filtrado = LARGURA'(w_soma >>> 2);

  // NOTE: sequential state uses non-blocking assignments so the window shifts as one register stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the window is reset on purpose, a restart must refill from zero; bulk memories normally skip this.
      for (int i = 0; i < 4; i++) r_janela[i] <= '0;
      r_ultimo  <= '0;
      r_cont    <= '0;
      r_falha   <= 1'b0;
      r_travado <= 1'b0;
    end else begin
      if (i_amostra_en) begin
        r_janela[0] <= w_aceita;
        for (int i = 1; i < 4; i++) r_janela[i] <= r_janela[i-1];
        if (!w_eh_falha) begin
          r_ultimo  <= i_bruto;
          r_cont    <= w_cont_prox;
          r_travado <= (w_cont_prox == LIMITE);
        end
      end
      // A new fault wins over a simultaneous clear.
      if (i_amostra_en && w_eh_falha)
        r_falha <= 1'b1;
      else if (i_limpar_falha)
        r_falha <= 1'b0;
    end
  end

  assign o_falha   = r_falha;
  assign o_travado = r_travado;

endmodule

// File: rtl/condicionador_pressao.sv
// Seven-channel pressure conditioner: fill-control FSM, registered filtered outputs,
// one-cycle valid pulse per update and a registered sensor alarm.
module condicionador_pressao import pressao_pkg::*; #(
  parameter int LIMITE_TRAVADO = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  condicionador_pressao_if.slave  bus
);

  logic [NUM_CANAIS*LARGURA-1:0] w_filtrado;
  logic [NUM_CANAIS-1:0]         w_falha;
  logic [NUM_CANAIS-1:0]         w_travado;

  estado_t                       r_estado;
  logic [1:0]                    r_enche;
  logic                          r_atualiza;
  logic [NUM_CANAIS*LARGURA-1:0] r_pres;
  logic                          r_valido;
  logic                          r_alarme;

  for (genvar c = 0; c < NUM_CANAIS; c++) begin : g_canal
    canal_filtro #(.LIMITE_TRAVADO(LIMITE_TRAVADO)) u_canal (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_amostra_en   (bus.amostraEn),
      .i_limpar_falha (bus.limparFalha),
      .i_bruto        (bus.sensBruto[c*LARGURA +: LARGURA]),
      .o_filtrado     (w_filtrado[c*LARGURA +: LARGURA]),
      .o_falha        (w_falha[c]),
      .o_travado      (w_travado[c])
    );
  end

  // r_atualiza marks that the windows just took a sample while full; the
  // averaged result is latched one edge later together with the valid pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado   <= VAZIO;
      r_enche    <= 2'd0;
      r_atualiza <= 1'b0;
      r_pres     <= '0;
      r_valido   <= 1'b0;
      r_alarme   <= 1'b0;
    end else begin
      r_atualiza <= 1'b0;
      if (bus.amostraEn) begin
        case (r_estado)
          VAZIO: begin
            r_estado <= ENCHENDO;
            r_enche  <= 2'd1;
          end
          ENCHENDO: begin
            r_enche <= r_enche + 2'd1;
            if (r_enche == 2'd3) begin
              r_estado   <= OPERANDO;
              r_atualiza <= 1'b1;
            end
          end
          OPERANDO: r_atualiza <= 1'b1;
          default:  r_estado   <= VAZIO;
        endcase
      end
      r_valido <= r_atualiza;
      if (r_atualiza) r_pres <= w_filtrado;
      r_alarme <= |{w_falha, w_travado};
    end
  end

  assign bus.sensPres     = r_pres;
  assign bus.dadosValidos = r_valido;
  assign bus.falhaSensor  = w_falha;
  assign bus.travado      = w_travado;
  assign bus.alarmeSensor = r_alarme;

endmodule

// File: tb/tb_condicionador_pressao.sv
// Self-checking bench for condicionador_pressao: directed scenarios plus random
// traffic, every output compared each cycle against a behavioural model.
module tb_condicionador_pressao;
  import pressao_pkg::*;

  localparam int LIM = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  condicionador_pressao_if bus ();

  condicionador_pressao #(.LIMITE_TRAVADO(LIM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Behavioural model: per-channel list of accepted samples (index 0 newest),
  // number of strobes since reset, sticky faults and run lengths of equal values.
  int                          m_jan  [NUM_CANAIS][4];
  int                          m_corr [NUM_CANAIS];
  int                          m_ult  [NUM_CANAIS];
  int                          m_ench;
  bit                          m_pend;
  bit [NUM_CANAIS-1:0]         m_falha;
  bit [NUM_CANAIS-1:0]         m_trav;
  logic [NUM_CANAIS*LARGURA-1:0] e_pres;
  bit                          e_dv;
  bit                          e_alarme;

  function automatic int media(input int s);
    return (s >= 0) ? s / 4 : -((-s + 3) / 4);
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < NUM_CANAIS; c++) begin
      for (int i = 0; i < 4; i++) m_jan[c][i] = 0;
      m_corr[c] = 0;
      m_ult[c]  = 0;
    end
    m_ench   = 0;
    m_pend   = 1'b0;
    m_falha  = '0;
    m_trav   = '0;
    e_pres   = '0;
    e_dv     = 1'b0;
    e_alarme = 1'b0;
  endfunction

  function automatic void model_step(input bit en, input bit lim, input logic [27:0] bruto);
    int v, nova, s;
    e_alarme = (m_falha != '0) || (m_trav != '0);
    e_dv     = m_pend;
    if (m_pend) begin
      for (int c = 0; c < NUM_CANAIS; c++) begin
        s = m_jan[c][0] + m_jan[c][1] + m_jan[c][2] + m_jan[c][3];
        e_pres[c*LARGURA +: LARGURA] = 4'(media(s));
      end
    end
    m_pend = 1'b0;
    for (int c = 0; c < NUM_CANAIS; c++) begin
      v = $signed(bruto[c*LARGURA +: LARGURA]);
      if (en && v == -8) begin
        m_falha[c] = 1'b1;
        nova = m_jan[c][0];
      end else begin
        if (lim) m_falha[c] = 1'b0;
        nova = v;
        if (en) begin
          if (m_corr[c] > 0 && v == m_ult[c]) begin
            if (m_corr[c] < LIM) m_corr[c]++;
          end else begin
            m_corr[c] = 1;
          end
          m_ult[c]  = v;
          m_trav[c] = (m_corr[c] == LIM);
        end
      end
      if (en) begin
        for (int i = 3; i > 0; i--) m_jan[c][i] = m_jan[c][i-1];
        m_jan[c][0] = nova;
      end
    end
    if (en) begin
      if (m_ench < 4) m_ench++;
      if (m_ench == 4) m_pend = 1'b1;
    end
  endfunction

  function automatic logic [27:0] todos(input int v);
    logic [27:0] r;
    for (int c = 0; c < NUM_CANAIS; c++) r[c*LARGURA +: LARGURA] = 4'(v);
    return r;
  endfunction

  // Drives one clock's inputs, steps the model across the edge and compares all outputs.
  task automatic ciclo(input bit en, input bit lim, input logic [27:0] bruto);
    bus.amostraEn   = en;
    bus.limparFalha = lim;
    bus.sensBruto   = bruto;
    @(posedge clk);
    #1;
    model_step(en, lim, bruto);
    check("sensPres",     bus.sensPres,     e_pres);
    check("dadosValidos", bus.dadosValidos, e_dv);
    check("falhaSensor",  bus.falhaSensor,  m_falha);
    check("travado",      bus.travado,      m_trav);
    check("alarmeSensor", bus.alarmeSensor, e_alarme);
  endtask

  task automatic aplica_reset();
    bus.amostraEn   = 1'b0;
    bus.limparFalha = 1'b0;
    rst_n = 1'b0;
    #2;
    check("rst_sensPres",     bus.sensPres,     0);
    check("rst_dadosValidos", bus.dadosValidos, 0);
    check("rst_falhaSensor",  bus.falhaSensor,  0);
    check("rst_travado",      bus.travado,      0);
    check("rst_alarmeSensor", bus.alarmeSensor, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [27:0] b;
    logic [8:0]  seq;
    int          cur [NUM_CANAIS];
    int          vals_a [4];
    int          vals_b [4];

    rst_n           = 1'b1;
    bus.amostraEn   = 1'b0;
    bus.limparFalha = 1'b0;
    bus.sensBruto   = '0;
    #1;
    aplica_reset();

    // Fill with all channels at -1: no pulse during the fill, then one pulse with -1 everywhere.
    for (int i = 0; i < 4; i++) begin
      ciclo(1'b1, 1'b0, todos(-1));
      check("fill_dv_low", bus.dadosValidos, 0);
    end
    ciclo(1'b0, 1'b0, todos(-1));
    check("fill_pres", bus.sensPres, 28'hFFFFFFF);
    check("fill_dv",   bus.dadosValidos, 1);
    ciclo(1'b0, 1'b0, todos(-1));
    check("fill_dv_pulse", bus.dadosValidos, 0);

    // Floor rounding of the average on SC.
    vals_a = '{-1, -1, -2, -2};
    vals_b = '{1, 2, 2, 2};
    b = todos(-1);
    for (int i = 0; i < 4; i++) begin
      b[SC*LARGURA +: LARGURA] = 4'(vals_a[i]);
      ciclo(1'b1, 1'b0, b);
    end
    ciclo(1'b0, 1'b0, b);
    check("media_neg", bus.sensPres[SC*LARGURA +: LARGURA], 4'hE);
    for (int i = 0; i < 4; i++) begin
      b[SC*LARGURA +: LARGURA] = 4'(vals_b[i]);
      ciclo(1'b1, 1'b0, b);
    end
    ciclo(1'b0, 1'b0, b);
    check("media_pos", bus.sensPres[SC*LARGURA +: LARGURA], 4'h1);

    // Fault code on S2: previous sample is reused, flag is sticky, alarm follows a cycle later.
    for (int i = 0; i < 4; i++) begin
      b = todos(i);
      b[S2*LARGURA +: LARGURA] = 4'(4);
      ciclo(1'b1, 1'b0, b);
    end
    b = todos(5);
    b[S2*LARGURA +: LARGURA] = COD_FALHA;
    ciclo(1'b1, 1'b0, b);
    check("falha_set",     bus.falhaSensor[S2], 1);
    check("alarme_antes",  bus.alarmeSensor, 0);
    ciclo(1'b0, 1'b0, b);
    check("alarme_depois", bus.alarmeSensor, 1);
    check("falha_subst",   bus.sensPres[S2*LARGURA +: LARGURA], 4'h4);
    ciclo(1'b0, 1'b1, b);
    check("falha_limpa",   bus.falhaSensor[S2], 0);
    ciclo(1'b1, 1'b1, b);
    check("falha_vs_limpa", bus.falhaSensor[S2], 1);
    ciclo(1'b0, 1'b1, b);
    check("falha_limpa2",  bus.falhaSensor[S2], 0);

    // TubSR stuck at 3 for LIM strobes, released by a different value.
    b = todos(0);
    b[TUBSR*LARGURA +: LARGURA] = 4'(3);
    for (int i = 0; i < LIM - 1; i++) ciclo(1'b1, 1'b0, b);
    check("trav_antes", bus.travado[TUBSR], 0);
    ciclo(1'b1, 1'b0, b);
    check("trav_set",   bus.travado[TUBSR], 1);
    b[TUBSR*LARGURA +: LARGURA] = 4'(2);
    ciclo(1'b1, 1'b0, b);
    check("trav_clr",   bus.travado[TUBSR], 0);

    // Six back-to-back strobes give six consecutive valid cycles, one cycle late.
    ciclo(1'b0, 1'b0, b);
    for (int i = 0; i < 9; i++) begin
      b = 28'($urandom);
      ciclo(i < 6, 1'b0, b);
      seq[i] = bus.dadosValidos;
    end
    check("rajada_dv", seq, 9'h07E);

    // Reset in the middle of operation discards the windows.
    aplica_reset();
    for (int i = 0; i < 3; i++) begin
      ciclo(1'b1, 1'b0, todos(2));
      check("pos_rst_dv", bus.dadosValidos, 0);
    end
    ciclo(1'b1, 1'b0, todos(2));
    ciclo(1'b0, 1'b0, todos(2));
    check("pos_rst_fill", bus.dadosValidos, 1);

    // Random traffic with held values so stuck runs and faults both occur.
    for (int c = 0; c < NUM_CANAIS; c++) cur[c] = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(499) == 0) aplica_reset();
      for (int c = 0; c < NUM_CANAIS; c++) begin
        if ($urandom_range(7) == 0) cur[c] = int'($urandom_range(15)) - 8;
        b[c*LARGURA +: LARGURA] = 4'(cur[c]);
      end
      ciclo($urandom_range(9) < 6, $urandom_range(15) == 0, b);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
